vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Produces the raster timing that the game renderer consumes: hCount, vCount, bright, plus the monitor syncs.
- Samples the renderer's combinational rgb and drives the blanked, sync-aligned pixel to the VGA pins.
- Emits a one-clk frame_tick, usable as the game-update strobe in place of a divided slow clock.
- Sits between the 100 MHz board clock and the VGA connector, one level above the block controller.

Parameters:
- CLK_DIV, 4, clk cycles per pixel (pixel-enable period); legal values 1..16.
- H_SYNC, 96, hsync width in pixels.
- H_BP, 48, horizontal back porch.
- H_VISIBLE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- V_SYNC, 2, vsync width in lines.
- V_BP, 33, vertical back porch.
- V_VISIBLE, 480, visible lines.
- V_FP, 10, vertical front porch.
- SYNC_ACTIVE_LOW, 1, 1 = syncs are low while asserted.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- rgb_in  in  12  renderer colour for the current (hCount, vCount).
- hCount  out  10  current pixel column, 0..H_TOTAL-1.
- vCount  out  10  current line, 0..V_TOTAL-1.
- bright  out  1  current pixel is in the visible window.
- pix_en  out  1  one-clk strobe every CLK_DIV clks; counters advance on it.
- line_tick  out  1  one-clk pulse at the start of each line.
- frame_tick  out  1  one-clk pulse at the start of each frame.
- vga_hs  out  1  horizontal sync to the connector.
- vga_vs  out  1  vertical sync to the connector.
- vga_rgb  out  12  blanked pixel to the connector.

Behaviour:
- Reset is asynchronous, active-high, on clock clk.
- Derived constants:
  - H_TOTAL = H_SYNC+H_BP+H_VISIBLE+H_FP = 800.
  - V_TOTAL = 525.
  - H_START = H_SYNC+H_BP = 144; H_END = H_START+H_VISIBLE-1 = 783.
  - V_START = 35; V_END = 514.
- Reset values:
  - div, hCount, vCount, bright, pix_en, line_tick, frame_tick, vga_rgb = 0.
  - vga_hs, vga_vs = inactive level (1 when SYNC_ACTIVE_LOW).
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_en is registered, high for one clk when div wraps to 0.
  - CLK_DIV=1 gives pix_en constantly 1 after reset release.
  - The first pix_en occurs CLK_DIV clks after reset deasserts.
- Counters, all updated on a clk where pix_en is 1:
  - hCount increments; at H_TOTAL-1 it wraps to 0 and vCount increments.
  - vCount wraps from V_TOTAL-1 to 0.
  - No other clk edge changes the counters.
- bright = (H_START<=hCount<=H_END) && (V_START<=vCount<=V_END).
  - It is registered together with the counters, so it always describes the same pixel as hCount/vCount.
- line_tick is high for exactly one clk: the clk edge on which hCount becomes 0.
- frame_tick is high for exactly one clk: the edge on which (hCount, vCount) becomes (0,0).
  - line_tick is also high on that edge.
- Output pipeline, one pixel of latency:
  - On pix_en, vga_rgb <= bright ? rgb_in : 0.
  - On the same pix_en, vga_hs <= (hCount < H_SYNC) asserted; vga_vs <= (vCount < V_SYNC) asserted.
  - Syncs and colour are therefore mutually aligned, one pixel behind hCount/vCount.
  - rgb_in must be valid by the pix_en edge; it is combinational from hCount/vCount.
- Polarity: asserted level = ~SYNC_ACTIVE_LOW.
- Mid-frame reset: all state returns to the reset values immediately; there is no partial-frame completion.
- Widths: counters are 10 bits; parameter sets with H_TOTAL or V_TOTAL > 1024 are illegal and are rejected by an elaboration-time check.

Decomposition:
- vga_timing_pkg holds:
  - the default timing constants;
  - H_TOTAL/V_TOTAL/START/END derivation functions;
  - 12-bit colour constants (BLACK, WHITE, RED, BLUE, PINK, PURPLE) shared with the renderer.
- One sub-module, vga_pix_en_gen, contains the CLK_DIV counter and pix_en register.
- Raster counters, tick logic and output pipeline remain in vga_timing_gen.

Test Plan:
- Reset release with default parameters:
  - required: pix_en first high 4 clks later;
  - required: pix_en period is exactly 4 clks;
  - required: vga_hs=1, vga_vs=1, vga_rgb=0 during reset.
- Run 2 lines:
  - required: vga_hs is low for exactly 96 pixels (384 clks) per 800-pixel line;
  - required: line_tick period is 3200 clks.
- Full frame with rgb_in=12'hFFF:
  - required: vga_rgb nonzero only on 640x480 pixels, starting one pixel after (144,35) and ending one pixel after (783,514);
  - required: bright count is 307200 per frame.
- Frame timing:
  - required: frame_tick period is 1,680,000 clks;
  - required: vga_vs is low for 2 lines (6400 clks);
  - required: frame_tick coincides with line_tick.
- Assert rst at hCount=400, vCount=200:
  - required: all outputs return to reset values within the same clk;
  - required: after release, counting restarts from (0,0).
- CLK_DIV=1, SYNC_ACTIVE_LOW=0:
  - required: counters advance every clk;
  - required: hsync is high for 96 clks;
  - required: reset level of vga_hs/vga_vs is 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, raster derivation helpers and the renderer colour palette.
// Defaults describe 640x480 at 60 Hz from a 100 MHz clock with a 25 MHz pixel rate.
package vga_timing_pkg;

  localparam int DEF_CLK_DIV   = 4;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;

  localparam int COUNT_W   = 10;
  localparam int COUNT_MAX = 1 << COUNT_W;

  localparam logic [11:0] BLACK  = 12'h000;
  localparam logic [11:0] WHITE  = 12'hFFF;
  localparam logic [11:0] RED    = 12'hF00;
  localparam logic [11:0] BLUE   = 12'h00F;
  localparam logic [11:0] PINK   = 12'hF6B;
  localparam logic [11:0] PURPLE = 12'h80F;

  // Connector-side signals, registered together so they stay mutually aligned.
  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } vga_pins_t;

  function automatic int raster_total(input int sync, input int bp, input int vis, input int fp);
    return sync + bp + vis + fp;
  endfunction

  function automatic int first_visible(input int sync, input int bp);
    return sync + bp;
  endfunction

  function automatic int last_visible(input int sync, input int bp, input int vis);
    return sync + bp + vis - 1;
  endfunction

endpackage

// File: rtl/vga_pix_en_gen.sv
// Pixel-rate enable: a one-clk pix_en strobe every CLK_DIV clocks, first one
// CLK_DIV clocks after reset is released.
module vga_pix_en_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_clk_div
    $error("vga_pix_en_gen: CLK_DIV must be in 1..16");
  end

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0] div;
  logic       div_wrap;

  assign div_wrap = (div == DIV_LAST);

  // NOTE: every register here has an async reset term; the sensitivity list
  // carries posedge rst so it acts without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div    <= '0;
      pix_en <= 1'b0;
    end else begin
      div    <= div_wrap ? 4'd0 : div + 4'd1;
      pix_en <= div_wrap;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, visible-window flag, line/frame ticks and
// a one-pixel output stage that blanks the renderer colour and drives the syncs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV         = DEF_CLK_DIV,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BP            = DEF_H_BP,
  parameter int H_VISIBLE       = DEF_H_VISIBLE,
  parameter int H_FP            = DEF_H_FP,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BP            = DEF_V_BP,
  parameter int V_VISIBLE       = DEF_V_VISIBLE,
  parameter int V_FP            = DEF_V_FP,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] rgb_in,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        pix_en,
  output logic        line_tick,
  output logic        frame_tick,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [11:0] vga_rgb
);

  localparam int H_TOTAL = raster_total(H_SYNC, H_BP, H_VISIBLE, H_FP);
  localparam int V_TOTAL = raster_total(V_SYNC, V_BP, V_VISIBLE, V_FP);
  localparam int H_START = first_visible(H_SYNC, H_BP);
  localparam int H_END   = last_visible(H_SYNC, H_BP, H_VISIBLE);
  localparam int V_START = first_visible(V_SYNC, V_BP);
  localparam int V_END   = last_visible(V_SYNC, V_BP, V_VISIBLE);

  if (H_TOTAL > COUNT_MAX || V_TOTAL > COUNT_MAX) begin : g_bad_raster
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must fit the 10-bit counters");
  end

  if (H_VISIBLE < 1 || V_VISIBLE < 1 || H_SYNC < 1 || V_SYNC < 1) begin : g_bad_window
    $error("vga_timing_gen: sync widths and visible sizes must be at least 1");
  end

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_FIRST_V = 10'(H_START);
  localparam logic [9:0] H_LAST_V  = 10'(H_END);
  localparam logic [9:0] V_FIRST_V = 10'(V_START);
  localparam logic [9:0] V_LAST_V  = 10'(V_END);
  localparam logic [9:0] H_SYNC_W  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W  = 10'(V_SYNC);

  localparam logic SYNC_ON  = ~SYNC_ACTIVE_LOW;
  localparam logic SYNC_OFF = SYNC_ACTIVE_LOW;

  vga_pix_en_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_pix_en (
    .clk   (clk),
    .rst   (rst),
    .pix_en(pix_en)
  );

  function automatic logic in_window(input logic [9:0] h, input logic [9:0] v);
    return (h >= H_FIRST_V) && (h <= H_LAST_V) && (v >= V_FIRST_V) && (v <= V_LAST_V);
  endfunction

  logic       h_wrap;
  logic       v_wrap;
  logic [9:0] h_next;
  logic [9:0] v_next;

  // NOTE: every output of this block is given a value on every path, so no
  // latch can be inferred even as the wrap conditions grow.
  always_comb begin
    h_wrap = (hCount == H_LAST);
    v_wrap = (vCount == V_LAST);
    h_next = hCount + 10'd1;
    v_next = vCount;
    if (h_wrap) begin
      h_next = '0;
      v_next = v_wrap ? 10'd0 : vCount + 10'd1;
    end
  end

  // bright is computed from the next position so it lands in the same register
  // update as the counters it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hCount     <= '0;
      vCount     <= '0;
      bright     <= 1'b0;
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values of hCount/vCount regardless of statement order.
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
      if (pix_en) begin
        hCount     <= h_next;
        vCount     <= v_next;
        bright     <= in_window(h_next, v_next);
        line_tick  <= h_wrap;
        frame_tick <= h_wrap && v_wrap;
      end
    end
  end

  vga_pins_t pins;

  // Output stage captures the pixel currently shown on hCount/vCount, so the
  // connector runs exactly one pixel behind the counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pins <= '{hs: SYNC_OFF, vs: SYNC_OFF, rgb: BLACK};
    end else if (pix_en) begin
      pins.rgb <= bright ? rgb_in : BLACK;
      pins.hs  <= (hCount < H_SYNC_W) ? SYNC_ON : SYNC_OFF;
      pins.vs  <= (vCount < V_SYNC_W) ? SYNC_ON : SYNC_OFF;
    end
  end

  assign vga_hs  = pins.hs;
  assign vga_vs  = pins.vs;
  assign vga_rgb = pins.rgb;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing probe table, plus two reduced rasters
// (divided and undivided) checked every clock against an arithmetic raster model.
module tb_vga_timing_gen;

  // Reduced raster shared by the small and fast instances.
  localparam int S_HS  = 5;
  localparam int S_HBP = 3;
  localparam int S_HV  = 8;
  localparam int S_HFP = 2;
  localparam int S_VS  = 2;
  localparam int S_VBP = 3;
  localparam int S_VV  = 4;
  localparam int S_VFP = 1;
  localparam int S_HT  = 18;
  localparam int S_VT  = 10;
  localparam int S_D   = 3;
  localparam int F_D   = 1;

  typedef struct packed {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        bright;
    logic        pix_en;
    logic        line_tick;
    logic        frame_tick;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } obs_t;

  typedef struct {
    int          e;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } mdl_t;

  typedef struct {
    int          e;
    int          h;
    int          v;
    bit          pix_en;
    bit          line_tick;
    bit          hs;
    bit          vs;
    bit          bright;
    logic [11:0] rgb;
  } def_vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_s;
  logic [11:0] rgb_d, rgb_s, rgb_f;

  logic [9:0]  h_d, v_d, h_s, v_s, h_f, v_f;
  logic        br_d, pe_d, lt_d, ft_d, hs_d, vs_d;
  logic        br_s, pe_s, lt_s, ft_s, hs_s, vs_s;
  logic        br_f, pe_f, lt_f, ft_f, hs_f, vs_f;
  logic [11:0] out_d, out_s, out_f;

  vga_timing_gen dut_def (
    .clk(clk), .rst(rst_a), .rgb_in(rgb_d),
    .hCount(h_d), .vCount(v_d), .bright(br_d), .pix_en(pe_d),
    .line_tick(lt_d), .frame_tick(ft_d), .vga_hs(hs_d), .vga_vs(vs_d), .vga_rgb(out_d)
  );

  vga_timing_gen #(
    .CLK_DIV(S_D), .H_SYNC(S_HS), .H_BP(S_HBP), .H_VISIBLE(S_HV), .H_FP(S_HFP),
    .V_SYNC(S_VS), .V_BP(S_VBP), .V_VISIBLE(S_VV), .V_FP(S_VFP), .SYNC_ACTIVE_LOW(1'b1)
  ) dut_small (
    .clk(clk), .rst(rst_s), .rgb_in(rgb_s),
    .hCount(h_s), .vCount(v_s), .bright(br_s), .pix_en(pe_s),
    .line_tick(lt_s), .frame_tick(ft_s), .vga_hs(hs_s), .vga_vs(vs_s), .vga_rgb(out_s)
  );

  vga_timing_gen #(
    .CLK_DIV(F_D), .H_SYNC(S_HS), .H_BP(S_HBP), .H_VISIBLE(S_HV), .H_FP(S_HFP),
    .V_SYNC(S_VS), .V_BP(S_VBP), .V_VISIBLE(S_VV), .V_FP(S_VFP), .SYNC_ACTIVE_LOW(1'b0)
  ) dut_fast (
    .clk(clk), .rst(rst_a), .rgb_in(rgb_f),
    .hCount(h_f), .vCount(v_f), .bright(br_f), .pix_en(pe_f),
    .line_tick(lt_f), .frame_tick(ft_f), .vga_hs(hs_f), .vga_vs(vs_f), .vga_rgb(out_f)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic bit s_visible(input int h, input int v);
    return (h >= S_HS + S_HBP) && (h < S_HS + S_HBP + S_HV) &&
           (v >= S_VS + S_VBP) && (v < S_VS + S_VBP + S_VV);
  endfunction

  function automatic obs_t reset_obs(input bit sal);
    obs_t x;
    x     = '0;
    x.hs  = sal;
    x.vs  = sal;
    return x;
  endfunction

  // Position after e clock edges since release: the first pixel advance happens on
  // edge d+1, then every d edges, so k = (e-1)/d pixels have elapsed.
  task automatic model_edge(input int d, input bit sal, input logic [11:0] rgb_at_edge,
                            inout mdl_t m, output obs_t x);
    int k, h, v, p, ph, pv;
    bit adv;
    m.e = m.e + 1;
    k   = (m.e - 1) / d;
    adv = (m.e >= d + 1) && ((m.e - 1) % d == 0);
    h   = k % S_HT;
    v   = (k / S_HT) % S_VT;
    if (adv) begin
      p    = k - 1;
      ph   = p % S_HT;
      pv   = (p / S_HT) % S_VT;
      m.rgb = s_visible(ph, pv) ? rgb_at_edge : 12'h000;
      m.hs  = (ph < S_HS) ? !sal : sal;
      m.vs  = (pv < S_VS) ? !sal : sal;
    end
    x.h          = 10'(h);
    x.v          = 10'(v);
    x.bright     = s_visible(h, v);
    x.pix_en     = (m.e >= d) && (m.e % d == 0);
    x.line_tick  = adv && (h == 0);
    x.frame_tick = adv && (h == 0) && (v == 0);
    x.hs         = m.hs;
    x.vs         = m.vs;
    x.rgb        = m.rgb;
  endtask

  mdl_t ms, mf;
  bit   fff_s = 1'b0;

  always @(posedge clk) begin : mon_small
    obs_t x, a;
    #1;
    if (rst_s) begin
      ms = '{e: 0, rgb: 12'h000, hs: 1'b1, vs: 1'b1};
      x  = reset_obs(1'b1);
    end else begin
      model_edge(S_D, 1'b1, rgb_s, ms, x);
    end
    a = {h_s, v_s, br_s, pe_s, lt_s, ft_s, hs_s, vs_s, out_s};
    check("small_cycle", 64'(a), 64'(x));
    rgb_s = fff_s ? 12'hFFF : 12'($urandom);
  end

  always @(posedge clk) begin : mon_fast
    obs_t x, a;
    #1;
    if (rst_a) begin
      mf = '{e: 0, rgb: 12'h000, hs: 1'b0, vs: 1'b0};
      x  = reset_obs(1'b0);
    end else begin
      model_edge(F_D, 1'b0, rgb_f, mf, x);
    end
    a = {h_f, v_f, br_f, pe_f, lt_f, ft_f, hs_f, vs_f, out_f};
    check("fast_cycle", 64'(a), 64'(x));
    rgb_f = 12'($urandom);
  end

  initial begin
    def_vec_t tbl [14];
    int ti, first_pe, prev_pe, n_pe, lt_prev, n_lt, hs_low, vs_low;
    int vs_low_s, bright_px, rgb_nz, ft_extra, hs_high;
    bit found;

    // e, hCount, vCount, pix_en, line_tick, vga_hs, vga_vs, bright, vga_rgb
    tbl = '{
      '{0,    0,   0, 0, 0, 1, 1, 0, 12'h000},
      '{3,    0,   0, 0, 0, 1, 1, 0, 12'h000},
      '{4,    0,   0, 1, 0, 1, 1, 0, 12'h000},
      '{5,    1,   0, 0, 0, 0, 0, 0, 12'h000},
      '{8,    1,   0, 1, 0, 0, 0, 0, 12'h000},
      '{9,    2,   0, 0, 0, 0, 0, 0, 12'h000},
      '{388,  96,  0, 1, 0, 0, 0, 0, 12'h000},
      '{389,  97,  0, 0, 0, 1, 0, 0, 12'h000},
      '{3200, 799, 0, 1, 0, 1, 0, 0, 12'h000},
      '{3201, 0,   1, 0, 1, 1, 0, 0, 12'h000},
      '{3202, 0,   1, 0, 0, 1, 0, 0, 12'h000},
      '{3205, 1,   1, 0, 0, 0, 0, 0, 12'h000},
      '{6401, 0,   2, 0, 1, 1, 0, 0, 12'h000},
      '{6405, 1,   2, 0, 0, 0, 1, 0, 12'h000}
    };

    rst_a = 1'b1;
    rst_s = 1'b1;
    rgb_d = 12'hFFF;
    rgb_s = 12'h000;
    rgb_f = 12'h000;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("def_rst_hs",  64'(hs_d),  64'(1));
    check("def_rst_vs",  64'(vs_d),  64'(1));
    check("def_rst_rgb", 64'(out_d), 64'(0));
    check("fast_rst_hs", 64'(hs_f),  64'(0));
    check("fast_rst_vs", 64'(vs_f),  64'(0));
    rst_a = 1'b0;
    rst_s = 1'b0;
    #1;

    ti = 0; first_pe = -1; prev_pe = -1; n_pe = 0;
    lt_prev = -1; n_lt = 0; hs_low = 0; vs_low = 0;
    for (int e = 0; e <= 6410; e++) begin
      if (e > 0) begin
        @(posedge clk);
        #1;
        if (pe_d && e <= 400) begin
          n_pe++;
          if (first_pe < 0) first_pe = e;
          if (prev_pe >= 0) check("def_pix_en_period", 64'(e - prev_pe), 64'(4));
          prev_pe = e;
        end
        if (lt_d) begin
          if (lt_prev >= 0) check("def_line_tick_period", 64'(e - lt_prev), 64'(3200));
          lt_prev = e;
          n_lt++;
        end
        if (e >= 3201 && e <= 6400 && !hs_d) hs_low++;
        if (!vs_d) vs_low++;
      end
      if (ti < 14 && tbl[ti].e == e) begin
        check($sformatf("def_vec_e%0d", e),
              64'({h_d, v_d, pe_d, lt_d, hs_d, vs_d, br_d, out_d}),
              64'({10'(tbl[ti].h), 10'(tbl[ti].v), tbl[ti].pix_en, tbl[ti].line_tick,
                   tbl[ti].hs, tbl[ti].vs, tbl[ti].bright, tbl[ti].rgb}));
        ti++;
      end
    end
    check("def_table_reached", 64'(ti), 64'(14));
    check("def_first_pix_en", 64'(first_pe), 64'(4));
    check("def_pix_en_count", 64'(n_pe), 64'(100));
    check("def_line_tick_count", 64'(n_lt), 64'(2));
    check("def_hs_low_clks", 64'(hs_low), 64'(384));
    check("def_vs_low_clks", 64'(vs_low), 64'(6400));

    // One full reduced frame with white input, measured from a frame_tick.
    fff_s = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 1200 && !found; i++) begin
      @(posedge clk);
      #2;
      if (ft_s) found = 1'b1;
    end
    check("small_frame_tick_seen", 64'(found), 64'(1));
    vs_low_s = 0; bright_px = 0; rgb_nz = 0; ft_extra = 0;
    for (int c = 0; c < S_HT * S_VT * S_D; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #2;
        if (ft_s) ft_extra++;
      end
      if (ft_s) check("small_ft_with_lt", 64'(lt_s), 64'(1));
      if (!vs_s) vs_low_s++;
      if (pe_s && br_s) bright_px++;
      if (out_s != 12'h000) rgb_nz++;
    end
    @(posedge clk);
    #2;
    check("small_frame_period", 64'(ft_s), 64'(1));
    check("small_ft_extra", 64'(ft_extra), 64'(0));
    check("small_vs_low_clks", 64'(vs_low_s), 64'(S_VS * S_HT * S_D));
    check("small_bright_pixels", 64'(bright_px), 64'(S_HV * S_VV));
    check("small_rgb_nz_clks", 64'(rgb_nz), 64'(S_HV * S_VV * S_D));
    fff_s = 1'b0;

    // Mid-frame asynchronous reset, then restart from (0,0).
    found = 1'b0;
    for (int i = 0; i < 1200 && !found; i++) begin
      @(posedge clk);
      #2;
      if (h_s == 10'd10 && v_s == 10'd6) found = 1'b1;
    end
    check("small_mid_seen", 64'(found), 64'(1));
    rst_s = 1'b1;
    #1;
    check("small_mid_rst_outputs",
          64'({h_s, v_s, br_s, pe_s, lt_s, ft_s, hs_s, vs_s, out_s}),
          64'({10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000}));
    repeat (2) @(negedge clk);
    rst_s = 1'b0;
    for (int e = 1; e <= S_D + 1; e++) begin
      @(posedge clk);
      #2;
      if (e == S_D) check("small_restart_pe", 64'({pe_s, h_s, v_s}), 64'({1'b1, 10'd0, 10'd0}));
    end
    check("small_restart_pos", 64'({h_s, v_s}), 64'({10'd1, 10'd0}));

    // Undivided, active-high instance: one line from a line_tick.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk);
      #2;
      if (lt_f) found = 1'b1;
    end
    check("fast_line_tick_seen", 64'(found), 64'(1));
    hs_high = 0;
    for (int c = 0; c < S_HT; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #2;
      end
      check("fast_h_every_clk", 64'(h_f), 64'(c));
      if (hs_f) hs_high++;
    end
    check("fast_hs_high_clks", 64'(hs_high), 64'(S_HS));

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
